// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM.
// Every transaction takes three cycles: IDLE (grant), ACCESS (one strobe), DONE (ack).
// Optional write protection: define SRAM_ARB_PROTECT_EN to reject writes at or above PROT_BASE.
module sram_arbiter #(
  parameter int unsigned          ADDR_BITS = 16,
  parameter int unsigned          DATA_BITS = 8,
  parameter logic [ADDR_BITS-1:0] PROT_BASE = 16'hF000
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 req_a,
  input  logic                 wen_a,
  input  logic [ADDR_BITS-1:0] addr_a,
  input  logic [DATA_BITS-1:0] wdata_a,
  output logic                 ack_a,
  output logic [DATA_BITS-1:0] rdata_a,
  input  logic                 req_b,
  input  logic                 wen_b,
  input  logic [ADDR_BITS-1:0] addr_b,
  input  logic [DATA_BITS-1:0] wdata_b,
  output logic                 ack_b,
  output logic [DATA_BITS-1:0] rdata_b,
  output logic                 err,
  output logic                 read_enable,
  output logic                 write_enable,
  output logic [ADDR_BITS-1:0] address,
  output logic [DATA_BITS-1:0] write_data,
  input  logic [DATA_BITS-1:0] read_data
);

`ifdef SRAM_ARB_PROTECT_EN
  localparam bit ProtEn = 1'b1;
`else
  localparam bit ProtEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                 r_state;
  state_e                 w_state_d;
  logic                   r_ptr;    // 1: B wins a tie
  logic                   r_gnt_b;  // granted requester of the current transaction
  logic                   r_wen;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [DATA_BITS-1:0]   r_wdata;
  logic [DATA_BITS-1:0]   r_rdata_a;
  logic [DATA_BITS-1:0]   r_rdata_b;
  logic                   w_any_req;
  logic                   w_win_b;
  logic                   w_blocked;

  assign w_any_req = req_a | req_b;
  assign w_win_b   = req_b & (~req_a | r_ptr);
  // Constant 0 when protection is compiled out, so err is tied low.
  assign w_blocked = ProtEn & r_wen & (r_addr >= PROT_BASE);

  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state and state-decoded SRAM/ack outputs; reset forces IDLE so these drop at once
  always_comb begin
    w_state_d    = r_state;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    write_data   = '0;
    ack_a        = 1'b0;
    ack_b        = 1'b0;
    err          = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) w_state_d = StAccess;
      end
      StAccess: begin
        read_enable  = ~r_wen;
        write_enable = r_wen & ~w_blocked;
        address      = r_addr;
        write_data   = r_wdata;
        w_state_d    = StDone;
      end
      StDone: begin
        ack_a     = ~r_gnt_b;
        ack_b     = r_gnt_b;
        err       = w_blocked;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Grant: latch the winner's request and hand priority to the other side
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ptr   <= 1'b0;
      r_gnt_b <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == StIdle && w_any_req) begin
      r_ptr   <= ~w_win_b;
      r_gnt_b <= w_win_b;
      r_wen   <= w_win_b ? wen_b   : wen_a;
      r_addr  <= w_win_b ? addr_b  : addr_a;
      r_wdata <= w_win_b ? wdata_b : wdata_a;
    end
  end

  // Read capture at the end of ACCESS; writes leave both result registers untouched
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else if (r_state == StAccess && !r_wen) begin
      if (r_gnt_b) r_rdata_b <= read_data;
      else         r_rdata_a <= read_data;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, reset sequences and
// randomized traffic against a transaction-level reference model.
module tb_sram_arbiter;

`ifdef SRAM_ARB_PROTECT_EN
  localparam bit Prot = 1'b1;
`else
  localparam bit Prot = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req_a, wen_a, req_b, wen_b;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b;
  logic        ack_a, ack_b, err, read_enable, write_enable;
  logic [7:0]  rdata_a, rdata_b, write_data, read_data;
  logic [15:0] address;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .PROT_BASE(16'hF000)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_a(req_a), .wen_a(wen_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .wen_b(wen_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
    .err(err), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  // SRAM behavioural model; junk on read_data when not enabled
  logic [7:0] sram [0:65535];
  bit         mem_clr;
  assign read_data = read_enable ? sram[address] : 8'hEE;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) sram[i] <= 8'h00;
    end else if (write_enable) begin
      sram[address] <= write_data;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: serialized transactions, 3 edges each, tie broken by a toggling pointer
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  m_rd_a, m_rd_b;
  bit          m_ptr;
  int          edge_no, next_free;
  bit          x_valid, x_side, x_wr, x_blk;
  int          x_grant;
  logic [15:0] x_addr;
  logic [7:0]  x_wdata;
  bit          drop_a, drop_b;
  // Per-step / per-vector observations
  int          ack_side, obs_first;
  bit          got_a, got_b, obs_err;
  logic [7:0]  obs_rda, obs_rdb;

  task automatic model_reset();
    x_valid = 0; m_ptr = 0; m_rd_a = 8'h00; m_rd_b = 8'h00;
    edge_no = 0; next_free = 0; drop_a = 0; drop_b = 0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ack_a"}, ack_a, 0);
    chk({tag, " ack_b"}, ack_b, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " read_enable"}, read_enable, 0);
    chk({tag, " write_enable"}, write_enable, 0);
    chk({tag, " address"}, address, 0);
    chk({tag, " write_data"}, write_data, 0);
    chk({tag, " rdata_a"}, rdata_a, 0);
    chk({tag, " rdata_b"}, rdata_b, 0);
  endtask

  // One clock: predict the coming edge, apply it, check outputs at the following negedge
  task automatic step();
    bit   win_b;
    logic exp_re, exp_we, exp_aa, exp_ab, exp_err;
    int   last;
    if (n_rst && edge_no >= next_free && (req_a || req_b)) begin
      win_b     = req_b && (!req_a || m_ptr);
      m_ptr     = !win_b;
      x_valid   = 1; x_side = win_b; x_grant = edge_no;
      x_wr      = win_b ? wen_b : wen_a;
      x_addr    = win_b ? addr_b : addr_a;
      x_wdata   = win_b ? wdata_b : wdata_a;
      x_blk     = Prot && x_wr && (x_addr >= 16'hF000);
      next_free = edge_no + 3;
    end
    @(posedge clk);
    #1;
    if (drop_a) begin req_a = 0; drop_a = 0; end
    if (drop_b) begin req_b = 0; drop_b = 0; end
    last = edge_no;
    edge_no++;
    @(negedge clk);
    ack_side = -1;
    exp_re = x_valid && last == x_grant && !x_wr;
    exp_we = x_valid && last == x_grant && x_wr && !x_blk;
    chk("read_enable", read_enable, exp_re);
    chk("write_enable", write_enable, exp_we);
    chk("strobe exclusive", read_enable & write_enable, 0);
    if (x_valid && last == x_grant) begin
      chk("address", address, x_addr);
      chk("write_data", write_data, x_wdata);
    end else if (!x_valid && !req_a && !req_b) begin
      chk("idle address", address, 0);
      chk("idle write_data", write_data, 0);
    end
    exp_aa = 0; exp_ab = 0; exp_err = 0;
    if (x_valid && last == x_grant + 1) begin
      exp_aa  = !x_side; exp_ab = x_side; exp_err = x_blk;
      if (!x_wr) begin
        if (x_side) m_rd_b = ref_mem[x_addr];
        else        m_rd_a = ref_mem[x_addr];
      end else if (!x_blk) begin
        ref_mem[x_addr] = x_wdata;
      end
      x_valid = 0;
    end
    chk("ack_a", ack_a, exp_aa);
    chk("ack_b", ack_b, exp_ab);
    chk("err", err, exp_err);
    chk("rdata_a", rdata_a, m_rd_a);
    chk("rdata_b", rdata_b, m_rd_b);
    if (ack_a) begin
      drop_a = 1; ack_side = 0; got_a = 1; obs_rda = rdata_a;
      if (obs_first < 0) obs_first = 0;
    end
    if (ack_b) begin
      drop_b = 1; ack_side = 1; got_b = 1; obs_rdb = rdata_b;
      if (obs_first < 0) obs_first = 1;
    end
    if (err) obs_err = 1;
  endtask

  typedef struct {
    bit ra; bit wa; logic [15:0] adra; logic [7:0] da;
    bit rb; bit wb; logic [15:0] adrb; logic [7:0] db;
    int first; logic [7:0] rda; logic [7:0] rdb; bit err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    obs_first = -1; obs_err = 0; got_a = 0; got_b = 0;
    req_a = v.ra; wen_a = v.wa; addr_a = v.adra; wdata_a = v.da;
    req_b = v.rb; wen_b = v.wb; addr_b = v.adrb; wdata_b = v.db;
    for (int c = 0; c < 20 && !((got_a || !v.ra) && (got_b || !v.rb)); c++) step();
    chk({tag, " completed"}, (got_a || !v.ra) && (got_b || !v.rb), 1);
    step();
    chk({tag, " first served"}, obs_first, v.first);
    if (v.ra && !v.wa) chk({tag, " rdata_a"}, obs_rda, v.rda);
    if (v.rb && !v.wb) chk({tag, " rdata_b"}, obs_rdb, v.rdb);
    chk({tag, " err"}, obs_err, v.err);
  endtask

  task automatic rand_txn(output logic w, output logic [15:0] a, output logic [7:0] d);
    w = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) a = 16'hF000 + 16'($urandom_range(0, 1));
    else                           a = 16'($urandom_range(0, 7));
    d = 8'($urandom);
  endtask

  vec_t vecs[10];
  vec_t rv;

  initial begin
    int prev_side, acks;
    vecs[0] = '{1, 0, 16'd8, 8'h00, 1, 1, 16'd8, 8'h05, 0, 8'h00, 8'h00, 0};
    vecs[1] = '{1, 1, 16'd0, 8'hFF, 0, 0, 16'd0, 8'h00, 0, 8'h00, 8'h00, 0};
    vecs[2] = '{1, 0, 16'd0, 8'h00, 0, 0, 16'd0, 8'h00, 0, 8'hFF, 8'h00, 0};
    vecs[3] = '{0, 0, 16'd0, 8'h00, 1, 0, 16'd8, 8'h00, 1, 8'h00, 8'h05, 0};
    vecs[4] = '{1, 1, 16'd16, 8'h33, 1, 0, 16'd16, 8'h00, 0, 8'h00, 8'h33, 0};
    vecs[5] = '{0, 0, 16'd0, 8'h00, 1, 1, 16'hF000, 8'h11, 1, 8'h00, 8'h00, Prot};
    vecs[6] = '{1, 0, 16'hF000, 8'h00, 0, 0, 16'd0, 8'h00, 0, Prot ? 8'h00 : 8'h11, 8'h00, 0};
    vecs[7] = '{1, 0, 16'd0, 8'h00, 1, 0, 16'd8, 8'h00, 1, 8'hFF, 8'h05, 0};
    vecs[8] = '{1, 1, 16'd8, 8'h77, 1, 0, 16'd0, 8'h00, 1, 8'h00, 8'hFF, 0};
    vecs[9] = '{0, 0, 16'd0, 8'h00, 1, 0, 16'd8, 8'h00, 1, 8'h00, 8'h77, 0};
    rv      = '{1, 0, 16'd16, 8'h00, 1, 0, 16'd16, 8'h00, 0, 8'h00, 8'h00, 0};

    n_rst = 0; mem_clr = 1;
    req_a = 0; wen_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; wen_b = 0; addr_b = 0; wdata_b = 0;
    model_reset();
    @(posedge clk);
    #1;
    mem_clr = 0;
    chk_all_zero("reset");
    @(negedge clk);
    n_rst = 1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during ACCESS of a B write
    req_b = 1; wen_b = 1; addr_b = 16'd16; wdata_b = 8'h5A;
    step();
    chk("mid write strobe", write_enable, 1);
    n_rst = 0;
    #1;
    chk_all_zero("mid reset");
    req_b = 0; wen_b = 0; addr_b = 0; wdata_b = 0; mem_clr = 1;
    @(posedge clk);
    #1;
    mem_clr = 0;
    chk_all_zero("reset hold");
    @(negedge clk);
    n_rst = 1;
    model_reset();
    run_vec(rv, "post reset");

    // Both requesters always busy: acks must alternate
    prev_side = -1; acks = 0;
    for (int c = 0; c < 1000 && acks < 100; c++) begin
      if (!req_a && !drop_a) begin rand_txn(wen_a, addr_a, wdata_a); req_a = 1; end
      if (!req_b && !drop_b) begin rand_txn(wen_b, addr_b, wdata_b); req_b = 1; end
      step();
      if (ack_side >= 0) begin
        if (prev_side >= 0) chk("alternation", ack_side, 1 - prev_side);
        prev_side = ack_side;
        acks++;
      end
    end
    chk("continuous ack count", acks, 100);

    // Sparse random traffic
    for (int c = 0; c < 400; c++) begin
      if (!req_a && !drop_a && $urandom_range(0, 2) == 0) begin
        rand_txn(wen_a, addr_a, wdata_a); req_a = 1;
      end
      if (!req_b && !drop_b && $urandom_range(0, 2) == 0) begin
        rand_txn(wen_b, addr_b, wdata_b); req_b = 1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
